// File: rtl/snn_pkg.sv
// Shared types and the rate scaling rule for the spike rate decoder.
// Scaling is done at a fixed wide width so any WIDTH/WIN_LOG2 pair fits.
package snn_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int SCALE_W   = 64;

  typedef enum logic {IDLE, COUNT} dec_state_t;

  typedef struct packed {
    logic               sat;
    logic [SCALE_W-1:0] rate;
  } rate_res_t;

  // Map a window spike total onto the WIDTH-bit rate range, clipping at full scale.
  function automatic rate_res_t rate_scale(input logic [SCALE_W-1:0] total,
                                           input int width,
                                           input int win_log2);
    logic [SCALE_W-1:0] r;
    logic [SCALE_W-1:0] max_val;
    rate_res_t          res;
    if (win_log2 > width) r = total >> (win_log2 - width);
    else                  r = total << (width - win_log2);
    max_val  = (SCALE_W'(1) << width) - SCALE_W'(1);
    res.sat  = (r > max_val);
    res.rate = res.sat ? max_val : r;
    return res;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Control, spike input and rate output handshake of the spike rate decoder.
// master drives en/spike_in/rate_ready; slave is the decoder.
interface spike_rate_decoder_if
  import snn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             en;
  logic             spike_in;
  logic             rate_ready;
  logic [WIDTH-1:0] rate_out;
  logic             rate_valid;
  logic             sat;
  logic             overrun;

  modport master (
    output en, spike_in, rate_ready,
    input  rate_out, rate_valid, sat, overrun
  );

  modport slave (
    input  en, spike_in, rate_ready,
    output rate_out, rate_valid, sat, overrun
  );

endinterface

// File: rtl/spike_window_counter.sv
// Fixed-length window cycle counter and spike counter; flags the last cycle of
// each window and presents the total including that cycle's spike.
module spike_window_counter #(
  parameter int WIN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              spike_in,
  output logic              win_end,
  output logic [WIN_LOG2:0] total
);

  logic [WIN_LOG2-1:0] r_cyc_cnt;
  logic [WIN_LOG2:0]   r_spk_cnt;

  assign win_end = run && (r_cyc_cnt == '1);
  assign total   = r_spk_cnt + {{WIN_LOG2{1'b0}}, spike_in};

  // Leaving run discards the partial window, so the next run starts clean.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc_cnt <= '0;
      r_spk_cnt <= '0;
    end else if (!run) begin
      r_cyc_cnt <= '0;
      r_spk_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + WIN_LOG2'(1);
      r_spk_cnt <= win_end ? '0 : total;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Recovers the encoded weight from spike counts over fixed windows and offers
// one rate per window through a single-entry valid/ready output register.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WIN_LOG2 = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  spike_rate_decoder_if.slave  bus
);

  dec_state_t        r_state;
  logic [WIDTH-1:0]  r_rate_out;
  logic              r_rate_valid;
  logic              r_sat;
  logic              r_overrun;

  logic              w_win_end;
  logic [WIN_LOG2:0] w_total;
  rate_res_t         w_res;

  // The counter runs whenever en is high, so the IDLE->COUNT edge is already counted.
  spike_window_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .run      (bus.en),
    .spike_in (bus.spike_in),
    .win_end  (w_win_end),
    .total    (w_total)
  );

  assign w_res = rate_scale(SCALE_W'(w_total), WIDTH, WIN_LOG2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
      r_sat        <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state   <= COUNT;
            r_overrun <= 1'b0;
          end
        end
        COUNT: begin
          if (!bus.en) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A result accepted in the same cycle it is replaced leaves valid high.
      if (w_win_end) begin
        if (!r_rate_valid || bus.rate_ready) begin
          r_rate_out   <= WIDTH'(w_res.rate);
          r_sat        <= w_res.sat;
          r_rate_valid <= 1'b1;
        end else begin
          r_overrun    <= 1'b1;
        end
      end else if (r_rate_valid && bus.rate_ready) begin
        r_rate_valid <= 1'b0;
      end
    end
  end

  assign bus.rate_out   = r_rate_out;
  assign bus.rate_valid = r_rate_valid;
  assign bus.sat        = r_sat;
  assign bus.overrun    = r_overrun;

endmodule
